imm_instr_encoder: RTL and testbench
====================================

# imm_instr_encoder

Pipelined RISC-V instruction encoder: accepts a format selector, opcode, register fields, function fields and a 32-bit immediate, checks the immediate for representability, and emits the packed 32-bit instruction word. It is the inverse of the core's immediate decode and sits in the test and instruction-generation path feeding instruction memory or the fetch stage. It uses a valid/ready handshake at both ends, has 2-cycle latency and full throughput, and keeps saturating encode and error counters.

## Interface
- COUNT_W, 16, width of the enc_count and err_count counters.

- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- in_valid  in  1  input command valid.
- in_ready  out  1  encoder can accept a command this cycle.
- in_fmt  in  3  format select: 0 I, 1 S, 2 B, 3 U, 4 J, 5 R; 6 and 7 are illegal.
- in_opcode  in  7  instr[6:0], passed through verbatim.
- in_rd, in_rs1, in_rs2  in  5 each  register fields.
- in_funct3  in  3  function field; in_funct7  in  7  function field.
- in_imm  in  32  immediate as a two's-complement value. For U-format it is the full value, with imm[11:0] required to be zero.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out_instr  out  32  encoded instruction.
- out_err  out  1  command was not encodable.
- out_err_code  out  2  0 ok, 1 range, 2 misaligned, 3 illegal format.
- enc_count  out  COUNT_W  saturating count of output handshakes.
- err_count  out  COUNT_W  saturating count of output handshakes with out_err=1.

## Operation
- Stage 1 (S1) registers the accepted command. Stage 2 (S2) registers the checked and packed result, and S2 drives all out_* ports.
- Checks, in priority order: illegal format (3), then misaligned (2), then range (1).
  - Misaligned: B or J with imm[0]=1; U with imm[11:0]≠0.
  - Range for I and S: imm[31:11] must be all-equal, giving -2048..2047.
  - Range for B: imm[31:12] must be all-equal, giving -4096..4094.
  - Range for J: imm[31:20] must be all-equal, giving -1048576..1048574.
  - R and U formats have no range check.
- Packing, MSB to LSB:
  - I: imm[11:0], rs1, funct3, rd, opcode.
  - S: imm[11:5], rs2, rs1, funct3, imm[4:0], opcode.
  - B: imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode.
  - U: imm[31:12], rd, opcode.
  - J: imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode.
  - R: funct7, rs2, rs1, funct3, rd, opcode.
- Any error forces out_instr=32'h0000_0013 (addi x0,x0,0) and out_err=1. out_err_code identifies the highest-priority failing check.
- Fields not used by a format are ignored.
- Round-trip property: for every non-error command, decoding out_instr with the core's immediate decode returns in_imm for I, S, B, U and J.
- Counters update only on the output handshake (out_valid & out_ready). enc_count increments by 1, and err_count also increments by 1 when out_err=1. Both hold at all-ones once saturated.

## Timing
- Reset (async, rst_n=0):
  - S1 and S2 valid clear to 0, so out_valid=0.
  - out_instr=0, out_err=0, out_err_code=0.
  - Both counters are 0.
  - in_ready=1 from the first cycle after reset release.
- Reset asserted mid-operation discards all in-flight commands immediately. No output handshake completes while rst_n=0.
- Handshakes:
  - Input transfer when in_valid & in_ready.
  - Output transfer when out_valid & out_ready.
  - in_ready is combinational: !s1_valid | !out_valid | out_ready.
- Latency: a command accepted at edge N appears with out_valid=1 after edge N+1. It is held stable while out_ready=0.
- Throughput: one command per cycle when out_ready stays high.
- Backpressure:
  - S2 holds while out_ready=0.
  - S1 may fill, and then in_ready=0.
  - No command is dropped or duplicated.
  - A simultaneous output handshake and input acceptance in a full pipe advances both stages on the same edge.
- out_* ports are registered and show no combinational path from in_* ports. The only combinational path is out_ready to in_ready.

## Test plan
- I-type: fmt=0, opcode=0x13, rd=1, rs1=2, funct3=0, imm=-1 → out_instr=0xFFF10093, out_err=0, out_valid after 2 edges.
- B-type: fmt=2, opcode=0x63, rs1=1, rs2=2, funct3=0, imm=-4 → out_instr=0xFE208EE3. The same command with imm=3 → out_instr=0x00000013, code 2. With imm=4096 → code 1.
- U and J: fmt=3, opcode=0x37, rd=5, imm=0x12345000 → 0x123452B7. fmt=4, opcode=0x6F, rd=1, imm=2048 → 0x001000EF. fmt=7 → code 3, err_count increments.
- Backpressure: stream 8 commands back to back with out_ready toggled randomly → exactly 8 outputs in order, each stable while stalled, enc_count=8.
- Reset mid-stream: assert rst_n=0 with both stages full → out_valid drops asynchronously, counters read 0, and the first post-reset command encodes correctly.
- Saturation: with COUNT_W=4, perform 20 handshakes → enc_count stays at 15.

Source files
------------

// File: rtl/imm_instr_encoder.sv
// imm_instr_encoder
// Two-stage RISC-V instruction encoder. Stage 1 captures an accepted command.
// Stage 2 holds the checked, packed result and drives every out_* port.
// Any command that cannot be encoded becomes a NOP (addi x0,x0,0) with an
// error code. Saturating counters track output handshakes and errored outputs.
module imm_instr_encoder #(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_fmt,
    input  logic [6:0]         in_opcode,
    input  logic [4:0]         in_rd,
    input  logic [4:0]         in_rs1,
    input  logic [4:0]         in_rs2,
    input  logic [2:0]         in_funct3,
    input  logic [6:0]         in_funct7,
    input  logic [31:0]        in_imm,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [31:0]        out_instr,
    output logic               out_err,
    output logic [1:0]         out_err_code,
    output logic [COUNT_W-1:0] enc_count,
    output logic [COUNT_W-1:0] err_count
);

    localparam logic [2:0]  FMT_I = 3'd0;
    localparam logic [2:0]  FMT_S = 3'd1;
    localparam logic [2:0]  FMT_B = 3'd2;
    localparam logic [2:0]  FMT_U = 3'd3;
    localparam logic [2:0]  FMT_J = 3'd4;
    localparam logic [2:0]  FMT_R = 3'd5;

    localparam logic [1:0]  ERR_OK    = 2'd0;
    localparam logic [1:0]  ERR_RANGE = 2'd1;
    localparam logic [1:0]  ERR_ALIGN = 2'd2;
    localparam logic [1:0]  ERR_FMT   = 2'd3;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [COUNT_W-1:0] CNT_MAX = {COUNT_W{1'b1}};
    localparam logic [COUNT_W-1:0] CNT_ONE = {{(COUNT_W-1){1'b0}}, 1'b1};

    // True when imm[31:top] are all equal, i.e. the value fits as a signed
    // field whose sign bit sits at position top.
    function automatic logic fits_signed(input logic [31:0] imm, input logic [4:0] top);
        logic [31:0] sh;
        sh = 32'($signed(imm) >>> top);
        return (sh == 32'h0000_0000) || (sh == 32'hFFFF_FFFF);
    endfunction

    // Highest-priority failing check: illegal format, then alignment, then range.
    function automatic logic [1:0] check_cmd(input logic [2:0] fmt, input logic [31:0] imm);
        logic [1:0] code;
        code = ERR_OK;
        case (fmt)
            FMT_I, FMT_S: code = fits_signed(imm, 5'd11) ? ERR_OK : ERR_RANGE;
            FMT_B: begin
                if (imm[0]) begin
                    code = ERR_ALIGN;
                end else if (!fits_signed(imm, 5'd12)) begin
                    code = ERR_RANGE;
                end else begin
                    code = ERR_OK;
                end
            end
            FMT_J: begin
                if (imm[0]) begin
                    code = ERR_ALIGN;
                end else if (!fits_signed(imm, 5'd20)) begin
                    code = ERR_RANGE;
                end else begin
                    code = ERR_OK;
                end
            end
            FMT_U:   code = (imm[11:0] != 12'h000) ? ERR_ALIGN : ERR_OK;
            FMT_R:   code = ERR_OK;
            default: code = ERR_FMT;
        endcase
        return code;
    endfunction

    // Field placement for each format; unused fields are simply dropped.
    function automatic logic [31:0] pack_instr(
        input logic [2:0]  fmt,
        input logic [6:0]  opcode,
        input logic [4:0]  rd,
        input logic [4:0]  rs1,
        input logic [4:0]  rs2,
        input logic [2:0]  funct3,
        input logic [6:0]  funct7,
        input logic [31:0] imm
    );
        logic [31:0] w;
        case (fmt)
            FMT_I:   w = {imm[11:0], rs1, funct3, rd, opcode};
            FMT_S:   w = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            FMT_B:   w = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
            FMT_U:   w = {imm[31:12], rd, opcode};
            FMT_J:   w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
            FMT_R:   w = {funct7, rs2, rs1, funct3, rd, opcode};
            default: w = NOP_INSTR;
        endcase
        return w;
    endfunction

    logic        s1_valid_r;
    logic [2:0]  s1_fmt_r;
    logic [6:0]  s1_opcode_r;
    logic [4:0]  s1_rd_r;
    logic [4:0]  s1_rs1_r;
    logic [4:0]  s1_rs2_r;
    logic [2:0]  s1_funct3_r;
    logic [6:0]  s1_funct7_r;
    logic [31:0] s1_imm_r;

    logic        s2_valid_r;
    logic [31:0] s2_instr_r;
    logic        s2_err_r;
    logic [1:0]  s2_code_r;
    logic [COUNT_W-1:0] enc_count_r;
    logic [COUNT_W-1:0] err_count_r;

    logic        in_fire_s;
    logic        out_fire_s;
    logic        s2_load_s;
    logic        in_ready_s;
    logic [1:0]  chk_code_s;
    logic [31:0] next_instr_s;

    // Handshake decode: S2 takes S1 whenever it is empty or being drained.
    always_comb begin
        in_ready_s = !s1_valid_r || !s2_valid_r || out_ready;
        in_fire_s  = in_valid && in_ready_s;
        out_fire_s = s2_valid_r && out_ready;
        s2_load_s  = s1_valid_r && (!s2_valid_r || out_ready);
    end

    // Check and pack the command currently held in S1.
    always_comb begin
        chk_code_s = check_cmd(s1_fmt_r, s1_imm_r);
        if (chk_code_s != ERR_OK) begin
            next_instr_s = NOP_INSTR;
        end else begin
            next_instr_s = pack_instr(s1_fmt_r, s1_opcode_r, s1_rd_r, s1_rs1_r,
                                      s1_rs2_r, s1_funct3_r, s1_funct7_r, s1_imm_r);
        end
    end

    // Stage 1: capture accepted commands, empty when handed to S2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r  <= 1'b0;
            s1_fmt_r    <= 3'd0;
            s1_opcode_r <= 7'd0;
            s1_rd_r     <= 5'd0;
            s1_rs1_r    <= 5'd0;
            s1_rs2_r    <= 5'd0;
            s1_funct3_r <= 3'd0;
            s1_funct7_r <= 7'd0;
            s1_imm_r    <= 32'd0;
        end else if (in_fire_s) begin
            s1_valid_r  <= 1'b1;
            s1_fmt_r    <= in_fmt;
            s1_opcode_r <= in_opcode;
            s1_rd_r     <= in_rd;
            s1_rs1_r    <= in_rs1;
            s1_rs2_r    <= in_rs2;
            s1_funct3_r <= in_funct3;
            s1_funct7_r <= in_funct7;
            s1_imm_r    <= in_imm;
        end else if (s2_load_s) begin
            s1_valid_r  <= 1'b0;
        end else begin
            s1_valid_r  <= s1_valid_r;
        end
    end

    // Stage 2: register the encoded result; hold it while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_r <= 1'b0;
            s2_instr_r <= 32'd0;
            s2_err_r   <= 1'b0;
            s2_code_r  <= 2'd0;
        end else if (s2_load_s) begin
            s2_valid_r <= 1'b1;
            s2_instr_r <= next_instr_s;
            s2_err_r   <= (chk_code_s != ERR_OK);
            s2_code_r  <= chk_code_s;
        end else if (out_fire_s) begin
            s2_valid_r <= 1'b0;
        end else begin
            s2_valid_r <= s2_valid_r;
        end
    end

    // Saturating handshake counters, advanced only on an output transfer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            enc_count_r <= {COUNT_W{1'b0}};
            err_count_r <= {COUNT_W{1'b0}};
        end else if (out_fire_s) begin
            if (enc_count_r != CNT_MAX) begin
                enc_count_r <= enc_count_r + CNT_ONE;
            end else begin
                enc_count_r <= enc_count_r;
            end
            if (s2_err_r && (err_count_r != CNT_MAX)) begin
                err_count_r <= err_count_r + CNT_ONE;
            end else begin
                err_count_r <= err_count_r;
            end
        end else begin
            enc_count_r <= enc_count_r;
            err_count_r <= err_count_r;
        end
    end

    assign in_ready     = in_ready_s;
    assign out_valid    = s2_valid_r;
    assign out_instr    = s2_instr_r;
    assign out_err      = s2_err_r;
    assign out_err_code = s2_code_r;
    assign enc_count    = enc_count_r;
    assign err_count    = err_count_r;

endmodule

// File: tb/tb_imm_instr_encoder.sv
// Self-checking bench for imm_instr_encoder: directed encodings, reset,
// backpressure, saturation and randomized traffic against a reference model.
module tb_imm_instr_encoder;

    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    in_fmt;
    logic [6:0]    in_opcode;
    logic [4:0]    in_rd;
    logic [4:0]    in_rs1;
    logic [4:0]    in_rs2;
    logic [2:0]    in_funct3;
    logic [6:0]    in_funct7;
    logic [31:0]   in_imm;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_instr;
    logic          out_err;
    logic [1:0]    out_err_code;
    logic [CW-1:0] enc_count;
    logic [CW-1:0] err_count;

    imm_instr_encoder #(.COUNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
        .in_funct7(in_funct7), .in_imm(in_imm),
        .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
        .out_err(out_err), .out_err_code(out_err_code),
        .enc_count(enc_count), .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int m_enc = 0;
    int m_err = 0;
    logic [34:0] exp_q[$];
    logic        prev_stall = 1'b0;
    logic [34:0] held_word = 35'd0;
    logic        in_fire = 1'b0;
    logic        out_fire = 1'b0;

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: {err_code, err, instr} from the architectural encoding rules.
    function automatic logic [34:0] model(
        input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
        input logic [6:0] f7, input logic [31:0] imm);
        int signed   v;
        logic [1:0]  code;
        logic [31:0] w;
        logic [31:0] o32, rd32, r1, r2, f3w, f7w;
        v = $signed(imm);
        o32 = 32'(op); rd32 = 32'(rd); r1 = 32'(rs1); r2 = 32'(rs2);
        f3w = 32'(f3); f7w = 32'(f7);
        code = 2'd0;
        if (fmt > 3'd5) code = 2'd3;
        else if ((fmt == 3'd2 || fmt == 3'd4) && (imm % 32'd2 != 32'd0)) code = 2'd2;
        else if (fmt == 3'd3 && (imm % 32'd4096 != 32'd0)) code = 2'd2;
        else if ((fmt == 3'd0 || fmt == 3'd1) && (v < -2048 || v > 2047)) code = 2'd1;
        else if (fmt == 3'd2 && (v < -4096 || v > 4095)) code = 2'd1;
        else if (fmt == 3'd4 && (v < -1048576 || v > 1048575)) code = 2'd1;
        w = 32'h0000_0013;
        if (code == 2'd0) begin
            case (fmt)
                3'd0: w = ((imm & 32'hFFF) << 20) | (r1 << 15) | (f3w << 12) | (rd32 << 7) | o32;
                3'd1: w = (((imm >> 5) & 32'h7F) << 25) | (r2 << 20) | (r1 << 15) | (f3w << 12)
                          | ((imm & 32'h1F) << 7) | o32;
                3'd2: w = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (r2 << 20)
                          | (r1 << 15) | (f3w << 12) | (((imm >> 1) & 32'hF) << 8)
                          | (((imm >> 11) & 32'h1) << 7) | o32;
                3'd3: w = (imm & 32'hFFFF_F000) | (rd32 << 7) | o32;
                3'd4: w = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
                          | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12)
                          | (rd32 << 7) | o32;
                default: w = (f7w << 25) | (r2 << 20) | (r1 << 15) | (f3w << 12) | (rd32 << 7) | o32;
            endcase
        end
        return {code, (code != 2'd0), w};
    endfunction

    // One clock: sample handshakes and outputs before the edge, counters after.
    task automatic step();
        logic [34:0] exp_w;
        logic        exp_e;
        exp_e = 1'b0;
        #1;
        in_fire  = in_valid & in_ready;
        out_fire = out_valid & out_ready;
        if (prev_stall) begin
            chk("stall_hold", {4'd0, out_valid, out_err_code, out_err, out_instr}, {4'd0, 1'b1, held_word});
        end
        if (out_fire) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", 40'(out_valid), 40'd0);
            end else begin
                exp_w = exp_q.pop_front();
                exp_e = exp_w[32];
                chk("out_word", 40'({out_err_code, out_err, out_instr}), 40'(exp_w));
            end
        end
        prev_stall = out_valid & ~out_ready;
        held_word  = {out_err_code, out_err, out_instr};
        if (in_fire) exp_q.push_back(model(in_fmt, in_opcode, in_rd, in_rs1, in_rs2, in_funct3, in_funct7, in_imm));
        @(posedge clk);
        #1;
        if (out_fire) begin
            if (m_enc < CMAX) m_enc++;
            if (exp_e && m_err < CMAX) m_err++;
        end
        chk("enc_count", 40'(enc_count), 40'(m_enc));
        chk("err_count", 40'(err_count), 40'(m_err));
        @(negedge clk);
    endtask

    task automatic set_cmd(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                           input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                           input logic [31:0] imm);
        in_fmt = fmt; in_opcode = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7 = 7'h00; in_imm = imm;
    endtask

    task automatic rand_cmd();
        int k;
        in_fmt = 3'($urandom_range(0, 7));
        in_opcode = 7'($urandom); in_rd = 5'($urandom); in_rs1 = 5'($urandom);
        in_rs2 = 5'($urandom); in_funct3 = 3'($urandom); in_funct7 = 7'($urandom);
        k = $urandom_range(0, 4);
        case (k)
            0: in_imm = $urandom;
            1: in_imm = 32'(int'($urandom_range(0, 4095)) - 2048);
            2: in_imm = $urandom & 32'hFFFF_F000;
            3: in_imm = 32'(int'($urandom_range(0, 2097151)) - 1048576) & 32'hFFFF_FFFE;
            default: in_imm = 32'(int'($urandom_range(0, 8191)) - 4096) & 32'hFFFF_FFFE;
        endcase
    endtask

    // Single command through an empty pipe; checks latency and the literal result.
    task automatic send_one(input string tag, input logic [31:0] exp_instr, input logic [1:0] exp_code);
        in_valid = 1'b1; out_ready = 1'b1;
        step();
        chk({tag, "_lat1"}, 40'(out_valid), 40'd0);
        in_valid = 1'b0;
        step();
        chk({tag, "_lat2"}, 40'(out_valid), 40'd1);
        chk(tag, 40'({out_err_code, out_err, out_instr}), 40'({exp_code, (exp_code != 2'd0), exp_instr}));
        step();
    endtask

    task automatic drain();
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) step();
        chk("drain_timeout", 40'(exp_q.size()), 40'd0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_out", 40'({out_valid, out_err_code, out_err, out_instr}), 40'd0);
        chk("rst_cnt", 40'({enc_count, err_count}), 40'd0);
        exp_q.delete(); m_enc = 0; m_err = 0; prev_stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst_in_ready", 40'(in_ready), 40'd1);
    endtask

    initial begin
        int sent;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        set_cmd(3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 3'd0, 32'd0);
        @(posedge clk);
        @(negedge clk);
        do_reset();

        // Directed encodings
        set_cmd(3'd0, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 32'hFFFF_FFFF);
        send_one("i_type", 32'hFFF1_0093, 2'd0);
        set_cmd(3'd2, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'hFFFF_FFFC);
        send_one("b_type", 32'hFE20_8EE3, 2'd0);
        set_cmd(3'd2, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'd3);
        send_one("b_misalign", 32'h0000_0013, 2'd2);
        set_cmd(3'd2, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 32'd4096);
        send_one("b_range", 32'h0000_0013, 2'd1);
        set_cmd(3'd3, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 32'h1234_5000);
        send_one("u_type", 32'h1234_52B7, 2'd0);
        set_cmd(3'd4, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 32'd2048);
        send_one("j_type", 32'h0010_00EF, 2'd0);
        set_cmd(3'd7, 7'h13, 5'd1, 5'd2, 5'd3, 3'd0, 32'd0);
        send_one("illegal_fmt", 32'h0000_0013, 2'd3);
        set_cmd(3'd0, 7'h13, 5'd1, 5'd2, 5'd0, 3'd0, 32'd2048);
        send_one("i_range", 32'h0000_0013, 2'd1);

        // Fill both stages under backpressure, then reset mid-stream
        out_ready = 1'b0; in_valid = 1'b1;
        rand_cmd(); step();
        rand_cmd(); step();
        chk("full_in_ready", 40'(in_ready), 40'd0);
        do_reset();

        // Backpressure stream of 8 commands
        sent = 0;
        in_valid = 1'b1; rand_cmd();
        for (int b = 0; b < 200 && sent < 8; b++) begin
            out_ready = 1'($urandom_range(0, 1));
            step();
            if (in_fire) begin
                sent++;
                rand_cmd();
            end
        end
        chk("bp_sent", 40'(sent), 40'd8);
        in_valid = 1'b0;
        for (int b = 0; b < 200 && exp_q.size() > 0; b++) begin
            out_ready = 1'($urandom_range(0, 1));
            step();
        end
        drain();
        chk("bp_enc_count", 40'(enc_count), 40'd8);

        // Randomized traffic
        for (int r = 0; r < 300; r++) begin
            rand_cmd();
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        drain();

        // Saturation: 20 back-to-back handshakes
        do_reset();
        in_valid = 1'b1; out_ready = 1'b1;
        for (int s = 0; s < 20; s++) begin
            rand_cmd();
            step();
        end
        drain();
        chk("sat_enc_count", 40'(enc_count), 40'(CMAX));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
